cmd_scheduler: RTL and testbench
================================

CMD_SCHEDULER -- requirements
Module: cmd_scheduler

Interface
REQ-001 Parameter NUM_CORES, default 2: number of NTT cores; legal range 1..16.
REQ-002 Parameter FIFO_DEPTH, default 4: command queue depth; power of two, at least 2.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 cmd_valid  in  1  command present on cmd_data.
REQ-006 cmd_data  in  64  command; [63:56] opcode, [55:48] core index.
REQ-007 cmd_ready  out  1  queue accepts a command this cycle.
REQ-008 core_start  out  NUM_CORES  one-cycle start pulse per core.
REQ-009 core_ready  in  NUM_CORES  core idle.
REQ-010 dma_start  out  1  one-cycle DMA start pulse.
REQ-011 dma_ready  in  1  DMA idle.
REQ-012 halted  out  1  sticky; HALT retired and all engines idle.
REQ-013 err_illegal  out  1  sticky; an illegal command was dropped.
REQ-014 fifo_level  out  $clog2(FIFO_DEPTH)+1  current queue occupancy.
REQ-015 perf_dispatched, perf_stall_cycles  out  32 each  performance counters (see Configuration).

Function
REQ-016 Opcodes: HALT 0x00, NTT 0x01, DMA 0x02, FENCE 0x03; all others illegal.
REQ-017 A command is accepted on the edge where cmd_valid and cmd_ready are both high, and is pushed to the FIFO tail.
REQ-018 cmd_ready = !rst && !full && !halt_seen, where halt_seen is set on acceptance of HALT. A pop in the same cycle does not free a slot for a push while full.
REQ-019 Dispatch FSM states: IDLE (FIFO empty), ISSUE (head valid), FENCE_WAIT, HALT_WAIT, HALTED.
REQ-020 ISSUE, NTT: if the core index is below NUM_CORES and the target is ready and not masked, pop the head and pulse core_start[idx] high for exactly one cycle; otherwise hold (stall).
REQ-021 ISSUE, DMA: if dma_ready is high and DMA is not masked, pop and pulse dma_start for one cycle; otherwise hold.
REQ-022 Masking: a target started at edge t is treated as busy during cycle t+1 regardless of its ready input. Engines deassert ready within one cycle of start.
REQ-023 ISSUE, NTT with core index ≥ NUM_CORES, or any illegal opcode: pop, issue no pulse, set err_illegal.
REQ-024 ISSUE, FENCE: pop and go to FENCE_WAIT; return to ISSUE or IDLE once all core_ready bits and dma_ready are high and no mask is active.
REQ-025 ISSUE, HALT: pop and go to HALT_WAIT; go to HALTED and set halted when the same all-idle condition as REQ-024 holds. HALTED exits only on reset.
REQ-026 Dispatch is in-order; at most one pop per cycle; a stalled head blocks all later commands.
REQ-027 Minimum latency: with an empty queue and the target idle, the start pulse is high in the cycle after the acceptance edge plus one (2 edges total).
REQ-028 Back-to-back NTT commands to different idle cores issue on consecutive cycles.

Reset
REQ-029 On rst: FIFO flushed, fifo_level=0, FSM=IDLE, all start pulses 0, halted=0, err_illegal=0, halt_seen=0, masks cleared, perf counters 0.
REQ-030 Reset mid-operation discards queued commands and pending FENCE/HALT waits; no start pulse is emitted in the cycle following the reset edge.

Configuration
REQ-031 Macro CMD_SCHED_PERF_EN defined: perf_dispatched counts start pulses issued; perf_stall_cycles counts cycles in ISSUE with the head blocked. Both counters saturate at 0xFFFFFFFF.
REQ-032 Macro CMD_SCHED_PERF_EN undefined: both ports remain present and are tied to 0; no counter logic is built.

Structure
REQ-033 Package cmd_sched_pkg holds the opcode constants, the field bit positions, and the FSM state enum.
REQ-034 Sub-module cmd_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/level) implements the queue; the dispatch FSM lives in cmd_scheduler.

Verification
REQ-035 Send NTT to idx 1 with both cores ready: core_start=2'b10 for exactly one cycle, 2 edges after acceptance.
REQ-036 Hold core_ready[0]=0 and send NTT idx 0 followed by NTT idx 1: idx 1 does not issue until core 0 is ready; queue occupancy is 2, then 1, then 0.
REQ-037 With dma_ready held low, push 4 commands: cmd_ready drops after the 4th; fifo_level=4; a 5th push is not accepted.
REQ-038 Send NTT idx 5 with NUM_CORES=2, then opcode 0x7F: no pulse is issued; err_illegal=1; fifo_level returns to 0.
REQ-039 Send DMA, FENCE, NTT idx 0 with DMA busy for 10 cycles: the NTT pulse occurs only after dma_ready rises.
REQ-040 Send HALT with core 1 busy, then assert rst mid-HALT_WAIT: halted stays 0 and all outputs return to reset values. Send HALT again with all engines idle: halted=1 and cmd_ready=0.

Source files
------------

// File: rtl/cmd_sched_pkg.sv
// Shared definitions for the command scheduler: command field layout,
// opcode values and the dispatch FSM state encoding.
package cmd_sched_pkg;

    localparam int CMD_W   = 64;
    localparam int OPC_LSB = 56;
    localparam int OPC_W   = 8;
    localparam int IDX_LSB = 48;
    localparam int IDX_W   = 8;

    localparam logic [OPC_W-1:0] OPC_HALT  = 8'h00;
    localparam logic [OPC_W-1:0] OPC_NTT   = 8'h01;
    localparam logic [OPC_W-1:0] OPC_DMA   = 8'h02;
    localparam logic [OPC_W-1:0] OPC_FENCE = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_FENCE_WAIT = 3'd2,
        ST_HALT_WAIT  = 3'd3,
        ST_HALTED     = 3'd4
    } sched_state_e;

    // Extract the opcode byte from a full command word.
    function automatic logic [OPC_W-1:0] cmd_opcode(input logic [CMD_W-1:0] cmd);
        return cmd[OPC_LSB +: OPC_W];
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command queue with registered occupancy. Pushes while full
// and pops while empty are ignored.
module cmd_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o    = (level_q == LVL_FULL);
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign data_o    = mem_q[rd_ptr_q];
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/cmd_scheduler.sv
// In-order command dispatcher feeding NTT cores and a DMA engine.
// Optional performance counters are built when CMD_SCHED_PERF_EN is defined.
module cmd_scheduler
    import cmd_sched_pkg::*;
#(
    parameter int NUM_CORES  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    input  logic [CMD_W-1:0]            cmd_data,
    output logic                        cmd_ready,
    output logic [NUM_CORES-1:0]        core_start,
    input  logic [NUM_CORES-1:0]        core_ready,
    output logic                        dma_start,
    input  logic                        dma_ready,
    output logic                        halted,
    output logic                        err_illegal,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [31:0]                 perf_dispatched,
    output logic [31:0]                 perf_stall_cycles
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    sched_state_e         state_q, state_d;
    logic [NUM_CORES-1:0] core_start_q, core_start_d;
    logic                 dma_start_q, dma_start_d;
    logic                 halt_seen_q, halted_q, err_q;

    logic                 fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
    logic [CMD_W-1:0]     head_s;
    logic [OPC_W-1:0]     head_opc_s;
    logic [IDX_W-1:0]     head_idx_s;
    logic [NUM_CORES-1:0] tgt_sel_s;
    logic                 idx_ok_s, core_go_s, dma_go_s, all_idle_s;
    logic                 stall_s, err_set_s, halt_set_s;
    logic                 unused_payload_s;

    assign cmd_ready   = !rst && !fifo_full_s && !halt_seen_q;
    assign fifo_push_s = cmd_valid && cmd_ready;

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push_s),
        .data_i  (cmd_data),
        .pop_i   (fifo_pop_s),
        .data_o  (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .level_o (fifo_level)
    );

    assign head_opc_s       = cmd_opcode(head_s);
    assign head_idx_s       = head_s[IDX_LSB +: IDX_W];
    assign unused_payload_s = ^head_s[IDX_LSB-1:0];

    // One-hot decode of the head's core index.
    always_comb begin
        tgt_sel_s = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            tgt_sel_s[i] = (head_idx_s == 8'(i));
        end
    end

    // A start pulse currently on the wire masks that engine's ready input.
    assign idx_ok_s   = (head_idx_s < 8'(NUM_CORES));
    assign core_go_s  = |(tgt_sel_s & core_ready & ~core_start_q);
    assign dma_go_s   = dma_ready && !dma_start_q;
    assign all_idle_s = (&core_ready) && dma_ready && (core_start_q == '0) && !dma_start_q;

    // Dispatch decision and next-state selection.
    always_comb begin
        state_d      = state_q;
        fifo_pop_s   = 1'b0;
        core_start_d = '0;
        dma_start_d  = 1'b0;
        stall_s      = 1'b0;
        err_set_s    = 1'b0;
        halt_set_s   = 1'b0;
        case (state_q)
            ST_IDLE, ST_ISSUE: begin
                if (!fifo_empty_s) begin
                    case (head_opc_s)
                        OPC_NTT: begin
                            if (!idx_ok_s) begin
                                fifo_pop_s = 1'b1;
                                err_set_s  = 1'b1;
                            end else if (core_go_s) begin
                                fifo_pop_s   = 1'b1;
                                core_start_d = tgt_sel_s;
                            end else begin
                                stall_s = 1'b1;
                            end
                        end
                        OPC_DMA: begin
                            if (dma_go_s) begin
                                fifo_pop_s  = 1'b1;
                                dma_start_d = 1'b1;
                            end else begin
                                stall_s = 1'b1;
                            end
                        end
                        OPC_FENCE: begin
                            fifo_pop_s = 1'b1;
                            state_d    = ST_FENCE_WAIT;
                        end
                        OPC_HALT: begin
                            fifo_pop_s = 1'b1;
                            state_d    = ST_HALT_WAIT;
                        end
                        default: begin
                            fifo_pop_s = 1'b1;
                            err_set_s  = 1'b1;
                        end
                    endcase
                end else begin
                    stall_s = 1'b0;
                end
                if (state_d == state_q) begin
                    state_d = (fifo_push_s ||
                               (fifo_level > {{(LVL_W-1){1'b0}}, fifo_pop_s})) ? ST_ISSUE : ST_IDLE;
                end else begin
                    state_d = state_d;
                end
            end
            ST_FENCE_WAIT: begin
                if (all_idle_s) begin
                    state_d = (!fifo_empty_s || fifo_push_s) ? ST_ISSUE : ST_IDLE;
                end else begin
                    state_d = ST_FENCE_WAIT;
                end
            end
            ST_HALT_WAIT: begin
                if (all_idle_s) begin
                    state_d    = ST_HALTED;
                    halt_set_s = 1'b1;
                end else begin
                    state_d = ST_HALT_WAIT;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State, start pulses and sticky status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            core_start_q <= '0;
            dma_start_q  <= 1'b0;
            halt_seen_q  <= 1'b0;
            halted_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            core_start_q <= core_start_d;
            dma_start_q  <= dma_start_d;
            if (fifo_push_s && (cmd_opcode(cmd_data) == OPC_HALT)) begin
                halt_seen_q <= 1'b1;
            end
            if (halt_set_s) begin
                halted_q <= 1'b1;
            end
            if (err_set_s) begin
                err_q <= 1'b1;
            end
        end
    end

    assign core_start  = core_start_q;
    assign dma_start   = dma_start_q;
    assign halted      = halted_q;
    assign err_illegal = err_q;

`ifdef CMD_SCHED_PERF_EN
    logic [31:0] perf_disp_q, perf_stall_q;

    // Saturating dispatch and stall counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_disp_q  <= 32'h0;
            perf_stall_q <= 32'h0;
        end else begin
            if (((core_start_d != '0) || dma_start_d) && (perf_disp_q != 32'hFFFF_FFFF)) begin
                perf_disp_q <= perf_disp_q + 32'h1;
            end
            if (stall_s && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'h1;
            end
        end
    end

    assign perf_dispatched   = perf_disp_q;
    assign perf_stall_cycles = perf_stall_q;
`else
    logic unused_perf_s;
    assign unused_perf_s     = stall_s;
    assign perf_dispatched   = 32'h0;
    assign perf_stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_cmd_scheduler.sv
// Self-checking bench for cmd_scheduler: constant-expectation vectors and
// sequences, plus random traffic compared against a queue-based reference.
module tb_cmd_scheduler;
    localparam int NC    = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [63:0] cmd_data = 64'h0;
    logic        cmd_ready;
    logic [1:0]  core_start;
    logic [1:0]  core_ready = 2'b11;
    logic        dma_start;
    logic        dma_ready = 1'b1;
    logic        halted;
    logic        err_illegal;
    logic [2:0]  fifo_level;
    logic [31:0] perf_dispatched;
    logic [31:0] perf_stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;
    bit rand_mode = 1'b0;

    cmd_scheduler #(.NUM_CORES(NC), .FIFO_DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .cmd_valid         (cmd_valid),
        .cmd_data          (cmd_data),
        .cmd_ready         (cmd_ready),
        .core_start        (core_start),
        .core_ready        (core_ready),
        .dma_start         (dma_start),
        .dma_ready         (dma_ready),
        .halted            (halted),
        .err_illegal       (err_illegal),
        .fifo_level        (fifo_level),
        .perf_dispatched   (perf_dispatched),
        .perf_stall_cycles (perf_stall_cycles)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [63:0] mq[$];
    int          m_mode;     // 0 running, 1 fence wait, 2 halt wait, 3 halted
    bit          m_halt_seen, m_halted, m_err, m_ds;
    logic [1:0]  m_cs;
    int unsigned m_disp, m_stall;
    int          busy[NC];
    int          dbusy;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit          acc, pop, nds, idle;
        logic [1:0]  ncs;
        logic [63:0] h;
        logic [7:0]  opc, idx;
        if (rst) begin
            mq.delete();
            m_mode = 0; m_halt_seen = 0; m_halted = 0; m_err = 0;
            m_cs = 2'b00; m_ds = 0; m_disp = 0; m_stall = 0;
            return;
        end
        acc  = cmd_valid && !m_halt_seen && (mq.size() < DEPTH);
        pop  = 0; nds = 0; ncs = 2'b00;
        idle = (core_ready == 2'b11) && dma_ready && (m_cs == 2'b00) && !m_ds;
        if (m_mode == 0 && mq.size() > 0) begin
            h = mq[0]; opc = h[63:56]; idx = h[55:48];
            if (opc == 8'h01) begin
                if (idx >= 8'(NC)) begin
                    pop = 1; m_err = 1;
                end else if ((((core_ready & ~m_cs) >> idx) & 2'b01) != 2'b00) begin
                    pop = 1; ncs = 2'b01 << idx;
                end else begin
                    m_stall++;
                end
            end else if (opc == 8'h02) begin
                if (dma_ready && !m_ds) begin pop = 1; nds = 1; end
                else m_stall++;
            end else if (opc == 8'h03) begin
                pop = 1; m_mode = 1;
            end else if (opc == 8'h00) begin
                pop = 1; m_mode = 2;
            end else begin
                pop = 1; m_err = 1;
            end
        end else if (m_mode == 1 && idle) begin
            m_mode = 0;
        end else if (m_mode == 2 && idle) begin
            m_mode = 3; m_halted = 1;
        end
        if (pop) void'(mq.pop_front());
        if (acc) begin
            mq.push_back(cmd_data);
            if (cmd_data[63:56] == 8'h00) m_halt_seen = 1;
        end
        if (ncs != 2'b00 || nds) m_disp++;
        m_cs = ncs;
        m_ds = nds;
    endtask

    task automatic model_check();
        chk("cmd_ready", cmd_ready, !rst && (mq.size() < DEPTH) && !m_halt_seen);
        chk("core_start", core_start, m_cs);
        chk("dma_start", dma_start, m_ds);
        chk("halted", halted, m_halted);
        chk("err_illegal", err_illegal, m_err);
        chk("fifo_level", fifo_level, mq.size());
`ifdef CMD_SCHED_PERF_EN
        chk("perf_dispatched", perf_dispatched, m_disp);
        chk("perf_stall_cycles", perf_stall_cycles, m_stall);
`else
        chk("perf_dispatched", perf_dispatched, 0);
        chk("perf_stall_cycles", perf_stall_cycles, 0);
`endif
    endtask

    // Engines go busy on seeing their start pulse, and occasionally on their own.
    task automatic engines_update();
        for (int i = 0; i < NC; i++) begin
            if (m_cs[i]) busy[i] = $urandom_range(1, 4);
            else if (busy[i] > 0) busy[i]--;
            else if ($urandom_range(0, 7) == 0) busy[i] = 1;
            core_ready[i] = (busy[i] == 0);
        end
        if (m_ds) dbusy = $urandom_range(1, 6);
        else if (dbusy > 0) dbusy--;
        else if ($urandom_range(0, 7) == 0) dbusy = 2;
        dma_ready = (dbusy == 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        model_check();
        if (rand_mode) engines_update();
    endtask

    function automatic logic [63:0] mk(input logic [7:0] opc, input logic [7:0] idx);
        logic [63:0] r;
        r = {$urandom, $urandom};
        r[63:48] = {opc, idx};
        return r;
    endfunction

    function automatic logic [63:0] rand_cmd();
        int r;
        r = $urandom_range(0, 99);
        if (r < 50)      return mk(8'h01, 8'($urandom_range(0, 2)));
        else if (r < 75) return mk(8'h02, 8'h00);
        else if (r < 87) return mk(8'h03, 8'h00);
        else if (r < 97) return mk(8'($urandom_range(4, 255)), 8'h00);
        else             return mk(8'h00, 8'h00);
    endfunction

    task automatic send(input logic [63:0] d);
        cmd_valid = 1'b1;
        cmd_data  = d;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; cmd_valid = 1'b0;
        step();
        chk("rst_core_start", core_start, 2'b00);
        chk("rst_dma_start", dma_start, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_err", err_illegal, 1'b0);
        chk("rst_level", fifo_level, 3'd0);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [7:0] opc;
        logic [7:0] idx;
        logic [1:0] cr;
        logic       dr;
        logic [1:0] exp_cs;
        logic       exp_ds;
        logic       exp_err;
        logic [2:0] exp_lvl;
    } vec_t;

    vec_t vt[8];

    initial begin
        vt[0] = '{8'h01, 8'h01, 2'b11, 1'b1, 2'b10, 1'b0, 1'b0, 3'd0};
        vt[1] = '{8'h01, 8'h00, 2'b11, 1'b1, 2'b01, 1'b0, 1'b0, 3'd0};
        vt[2] = '{8'h02, 8'h00, 2'b11, 1'b1, 2'b00, 1'b1, 1'b0, 3'd0};
        vt[3] = '{8'h01, 8'h05, 2'b11, 1'b1, 2'b00, 1'b0, 1'b1, 3'd0};
        vt[4] = '{8'h7F, 8'h00, 2'b11, 1'b1, 2'b00, 1'b0, 1'b1, 3'd0};
        vt[5] = '{8'h03, 8'h00, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 3'd0};
        vt[6] = '{8'h01, 8'h00, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 3'd1};
        vt[7] = '{8'h02, 8'h00, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 3'd1};
        for (int i = 0; i < NC; i++) busy[i] = 0;
        dbusy = 0;

        // Single-command latency and pulse width.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            core_ready = vt[v].cr;
            dma_ready  = vt[v].dr;
            send(mk(vt[v].opc, vt[v].idx));
            chk("vec_accept_level", fifo_level, 3'd1);
            chk("vec_no_early_pulse", core_start, 2'b00);
            step();
            chk("vec_core_start", core_start, vt[v].exp_cs);
            chk("vec_dma_start", dma_start, vt[v].exp_ds);
            chk("vec_err", err_illegal, vt[v].exp_err);
            chk("vec_level", fifo_level, vt[v].exp_lvl);
            step();
            chk("vec_pulse_one_cycle", {core_start, dma_start}, 3'b000);
        end

        // Head-of-line blocking behind a busy core.
        do_reset();
        core_ready = 2'b10; dma_ready = 1'b1;
        send(mk(8'h01, 8'h00));
        chk("hol_level1", fifo_level, 3'd1);
        send(mk(8'h01, 8'h01));
        chk("hol_level2", fifo_level, 3'd2);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hol_blocked", core_start, 2'b00);
            chk("hol_level_hold", fifo_level, 3'd2);
        end
        core_ready = 2'b11;
        step();
        chk("hol_issue0", core_start, 2'b01);
        chk("hol_level_after0", fifo_level, 3'd1);
        step();
        chk("hol_issue1_b2b", core_start, 2'b10);
        chk("hol_level_after1", fifo_level, 3'd0);

        // Full queue with DMA busy, then DMA masking after a start.
        do_reset();
        core_ready = 2'b11; dma_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(mk(8'h02, 8'h00));
        chk("full_level", fifo_level, 3'd4);
        chk("full_ready_low", cmd_ready, 1'b0);
        send(mk(8'h01, 8'h00));
        chk("full_no_push", fifo_level, 3'd4);
        dma_ready = 1'b1;
        step();
        chk("full_dma1", dma_start, 1'b1);
        chk("full_level3", fifo_level, 3'd3);
        step();
        chk("full_dma_masked", dma_start, 1'b0);
        chk("full_level3_hold", fifo_level, 3'd3);
        step();
        chk("full_dma2", dma_start, 1'b1);
        chk("full_level2", fifo_level, 3'd2);

        // Illegal commands are dropped.
        do_reset();
        core_ready = 2'b11; dma_ready = 1'b1;
        send(mk(8'h01, 8'h05));
        send(mk(8'h7F, 8'h00));
        chk("ill_no_pulse_a", core_start, 2'b00);
        step();
        chk("ill_no_pulse_b", core_start, 2'b00);
        chk("ill_err", err_illegal, 1'b1);
        chk("ill_level0", fifo_level, 3'd0);

        // FENCE holds a later NTT until the DMA finishes.
        do_reset();
        core_ready = 2'b11; dma_ready = 1'b1;
        send(mk(8'h02, 8'h00));
        send(mk(8'h03, 8'h00));
        chk("fence_dma_pulse", dma_start, 1'b1);
        dma_ready = 1'b0;
        send(mk(8'h01, 8'h00));
        for (int k = 0; k < 10; k++) begin
            step();
            chk("fence_hold", core_start, 2'b00);
        end
        dma_ready = 1'b1;
        step();
        chk("fence_release_cycle", core_start, 2'b00);
        step();
        chk("fence_ntt_issue", core_start, 2'b01);

        // HALT with a busy core interrupted by reset, then a clean HALT.
        do_reset();
        core_ready = 2'b01; dma_ready = 1'b1;
        send(mk(8'h00, 8'h00));
        chk("halt_ready_drop", cmd_ready, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("halt_wait", halted, 1'b0);
        end
        do_reset();
        step();
        chk("halt_rst_ready", cmd_ready, 1'b1);
        chk("halt_rst_no_pulse", core_start, 2'b00);
        chk("halt_rst_halted", halted, 1'b0);
        core_ready = 2'b11;
        send(mk(8'h00, 8'h00));
        step();
        step();
        chk("halt_done", halted, 1'b1);
        chk("halt_ready_low", cmd_ready, 1'b0);
        send(mk(8'h01, 8'h00));
        chk("halt_no_accept", fifo_level, 3'd0);
        chk("halt_no_pulse", core_start, 2'b00);

        // Random traffic against the reference model.
        do_reset();
        rand_mode = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 199) == 0) || (m_mode == 3 && $urandom_range(0, 9) == 0);
            cmd_valid = ($urandom_range(0, 1) == 1);
            cmd_data  = rand_cmd();
            step();
        end
        rand_mode = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
